// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM encoding and default sizing for the CLA wrappers
package cla_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} cla_state_t;
  localparam int CLA_W = 32;
  localparam int CLA_LAT_DEF = 2;
endpackage

// File: rtl/cla_add64_seq_if.sv
// cla_add64_seq_if: request/result bus plus CLA feed/return lines; ovf exists only under CLA_ADD64_OVF_EN
interface cla_add64_seq_if #(parameter int W = 32);
  logic start, ci, busy, done, co, cla_ci, cla_co;
  logic [2*W-1:0] a, b, s;
  logic [W-1:0] cla_a, cla_b, cla_s;
`ifdef CLA_ADD64_OVF_EN
  logic ovf;
  modport master (output start, a, b, ci, cla_s, cla_co,
                  input busy, done, s, co, ovf, cla_a, cla_b, cla_ci);
  modport slave (input start, a, b, ci, cla_s, cla_co,
                 output busy, done, s, co, ovf, cla_a, cla_b, cla_ci);
`else
  modport master (output start, a, b, ci, cla_s, cla_co,
                  input busy, done, s, co, cla_a, cla_b, cla_ci);
  modport slave (input start, a, b, ci, cla_s, cla_co,
                 output busy, done, s, co, cla_a, cla_b, cla_ci);
`endif
endinterface

// File: rtl/cla_lat_cnt.sv
// cla_lat_cnt: 3-bit wait counter with clear; term flags count==LAT
module cla_lat_cnt #(parameter int LAT = 2) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  output logic term_o
);
  logic [2:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 3'd0 : cnt_q + 3'd1;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= 3'd0;
    else cnt_q <= cnt_d;
  assign term_o = cnt_q == 3'(LAT);
endmodule

// File: rtl/cla_add64_seq.sv
// cla_add64_seq: feeds a registered W-bit CLA low half then high half and assembles a 2W-bit sum
// Optional signed-overflow output enabled by CLA_ADD64_OVF_EN.
module cla_add64_seq
  import cla_pkg::*;
#(
  parameter int W = CLA_W,
  parameter int CLA_LAT = CLA_LAT_DEF
) (
  input logic clock,
  input logic reset,
  cla_add64_seq_if.slave bus
);
  cla_state_t state_q, state_d;
  logic [2*W-1:0] a_q, b_q, s_q;
  logic ci_q, carry_q, co_q, term, cnt_clr;
  assign cnt_clr = (state_q == IDLE) || (state_q == DONE) || term;
  cla_lat_cnt #(.LAT(CLA_LAT)) u_cnt (.clock(clock), .reset(reset), .clr_i(cnt_clr), .term_o(term));
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.start ? LO : IDLE;
      LO:   state_d = term ? HI : LO;
      HI:   state_d = term ? DONE : HI;
      DONE: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.busy   = state_q != IDLE;
    bus.done   = state_q == DONE;
    bus.cla_a  = state_q == LO ? a_q[W-1:0] : state_q == HI ? a_q[2*W-1:W] : '0;
    bus.cla_b  = state_q == LO ? b_q[W-1:0] : state_q == HI ? b_q[2*W-1:W] : '0;
    bus.cla_ci = state_q == LO ? ci_q : state_q == HI ? carry_q : 1'b0;
  end
  assign bus.s  = s_q;
  assign bus.co = co_q;
`ifdef CLA_ADD64_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) ovf_q <= 1'b0;
    else if (state_q == IDLE && bus.start) ovf_q <= 1'b0;
    else if (state_q == HI && term)
      ovf_q <= (a_q[2*W-1] == b_q[2*W-1]) && (bus.cla_s[W-1] != a_q[2*W-1]);
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      ci_q <= 1'b0;
      carry_q <= 1'b0;
      co_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      a_q <= bus.a;
      b_q <= bus.b;
      ci_q <= bus.ci;
      s_q <= '0;
      co_q <= 1'b0;
    end else if (state_q == LO && term) begin
      s_q[W-1:0] <= bus.cla_s;
      carry_q <= bus.cla_co;
    end else if (state_q == HI && term) begin
      s_q[2*W-1:W] <= bus.cla_s;
      co_q <= bus.cla_co;
    end
endmodule

// File: tb/tb_cla_add64_seq.sv
// tb_cla_add64_seq: directed vectors against a two-register CLA model; define CLA_ADD64_OVF_EN to cover ovf
module tb_cla_add64_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cla_add64_seq_if #(.W(32)) bus ();
  cla_add64_seq #(.W(32), .CLA_LAT(2)) dut (.clock(clk), .reset(rst), .bus(bus.slave));
  logic [31:0] ra, rb;
  logic rci;
  always_ff @(posedge clk) begin
    ra <= bus.cla_a;
    rb <= bus.cla_b;
    rci <= bus.cla_ci;
    {bus.cla_co, bus.cla_s} <= {1'b0, ra} + {1'b0, rb} + {32'd0, rci};
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv, input logic civ,
                        input logic [63:0] es, input logic eco, input logic hci, input logic eovf,
                        input bit inject);
    bus.a = av; bus.b = bv; bus.ci = civ; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({tag, " busy@E0"}, 64'(bus.busy), 64'd1);
    check({tag, " s cleared"}, bus.s, 64'd0);
    step();
    if (inject) begin bus.start = 1'b1; bus.a = ~av; bus.b = 64'h1234; bus.ci = ~civ; end
    step();
    bus.start = 1'b0;
    step();
    step();
    check({tag, " cla_a HI"}, 64'(bus.cla_a), 64'(av[63:32]));
    check({tag, " cla_ci HI"}, 64'(bus.cla_ci), 64'(hci));
    step();
    check({tag, " done@E5"}, 64'(bus.done), 64'd0);
    step();
    check({tag, " done@E6"}, 64'(bus.done), 64'd1);
    check({tag, " busy@E6"}, 64'(bus.busy), 64'd1);
    check({tag, " s"}, bus.s, es);
    check({tag, " co"}, 64'(bus.co), 64'(eco));
`ifdef CLA_ADD64_OVF_EN
    check({tag, " ovf"}, 64'(bus.ovf), 64'(eovf));
`else
    if (eovf === 1'bx) n_fail++;
`endif
    if (inject) begin bus.start = 1'b1; bus.a = 64'hDEAD; bus.b = 64'hBEEF; end
    step();
    bus.start = 1'b0;
    check({tag, " busy@E7"}, 64'(bus.busy), 64'd0);
    check({tag, " done@E7"}, 64'(bus.done), 64'd0);
    step();
    check({tag, " idle@E8"}, 64'(bus.busy), 64'd0);
    check({tag, " s held"}, bus.s, es);
  endtask
  initial begin
    int pulses;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    step();
    step();
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst s", bus.s, 64'd0);
    check("rst co", 64'(bus.co), 64'd0);
    check("rst cla_a", 64'(bus.cla_a), 64'd0);
    check("rst cla_ci", 64'(bus.cla_ci), 64'd0);
    rst = 1'b0;
    step();
    run_op("carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("mixed", 64'h135F_A562_0000_FFFF, 64'h3561_4642_FFFF_0000, 1'b1,
           64'h48C0_EBA5_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("busy", 64'h0000_0002_0000_0003, 64'h0000_0004_0000_0005, 1'b0,
           64'h0000_0006_0000_0008, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("after", 64'h1111_1111_2222_2222, 64'h0101_0101_0202_0202, 1'b0,
           64'h1212_1212_2424_2424, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CLA_ADD64_OVF_EN
    run_op("ovf pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("ovf neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    bus.a = 64'h0000_0005_0000_0007; bus.b = 64'h0000_0003_0000_0001; bus.ci = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    check("pre-rst s low", bus.s, 64'h0000_0000_0000_0008);
    check("pre-rst cla_a", 64'(bus.cla_a), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("arst busy", 64'(bus.busy), 64'd0);
    check("arst done", 64'(bus.done), 64'd0);
    check("arst s", bus.s, 64'd0);
    check("arst co", 64'(bus.co), 64'd0);
    check("arst cla_a", 64'(bus.cla_a), 64'd0);
    check("arst cla_b", 64'(bus.cla_b), 64'd0);
    check("arst cla_ci", 64'(bus.cla_ci), 64'd0);
    step();
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      step();
      if (bus.done) pulses++;
    end
    check("no done after rst", 64'(pulses), 64'd0);
    check("idle after rst", 64'(bus.busy), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
